// File: rtl/data_bus_sink_pkg.sv
// Shared definitions for the data-bus write end and the bus mux:
// bus destination indices, default widths and the write-select legality check.
package data_bus_sink_pkg;

  localparam int REG_COUNT = 16;
  localparam int REG_WIDTH = 12;
  localparam int RF_ADDR_W = 4;

  localparam int BUS_AC = 0;
  localparam int BUS_PC = 1;
  localparam int BUS_AR = 2;
  localparam int BUS_IR = 3;
  localparam int BUS_RF = 4;
  localparam int BUS_DR = 15;

  typedef logic [REG_COUNT-1:0] write_en_t;

  localparam write_en_t LEGAL_MASK = write_en_t'((1 << BUS_AC) | (1 << BUS_PC) |
                                                 (1 << BUS_AR) | (1 << BUS_IR) |
                                                 (1 << BUS_RF) | (1 << BUS_DR));

  // Legal when no reserved bit is set and at most one bit is set (all-zero is a no-op).
  function automatic logic write_sel_legal(input write_en_t sel);
    write_en_t below;
    below = sel - write_en_t'(1);
    return ((sel & ~LEGAL_MASK) == '0) && ((sel & below) == '0);
  endfunction

endpackage

// File: rtl/data_bus_sink_load_inc_reg.sv
// Architectural register with bus load, synchronous clear and increment.
// Priority: load > clear > increment; increment wraps modulo 2^width.
module load_inc_reg #(
  parameter int width = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] val_q;
  logic [width-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = d_i;
    end else if (clr_i) begin
      val_d = '0;
    end else if (inc_i) begin
      val_d = val_q + width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/data_bus_sink.sv
// Write end of the shared data bus: one-hot destination select into AC/PC/AR/IR/DR
// or the register-file write port, with PC/AR increment, AC clear and a sticky error flag.
module data_bus_sink
  import data_bus_sink_pkg::*;
#(
  parameter int Reg_count = REG_COUNT,
  parameter int reg_width = REG_WIDTH,
  parameter int RF_ADDR_W = data_bus_sink_pkg::RF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [reg_width-1:0] datain,
  input  logic [Reg_count-1:0] write_en,
  input  logic [RF_ADDR_W-1:0] rf_sel,
  input  logic                 inc_pc,
  input  logic                 inc_ar,
  input  logic                 clr_ac,
  input  logic                 err_clr,
  output logic [reg_width-1:0] AC,
  output logic [reg_width-1:0] PC,
  output logic [reg_width-1:0] AR,
  output logic [reg_width-1:0] IR,
  output logic [reg_width-1:0] DR,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [reg_width-1:0] rf_wdata,
  output logic                 wr_err
);

  logic legal;
  logic ld_ac, ld_pc, ld_ar, ld_ir, ld_rf, ld_dr;

  logic [reg_width-1:0] ir_q, ir_d;
  logic [reg_width-1:0] dr_q, dr_d;
  logic                 rf_we_q, rf_we_d;
  logic [RF_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [reg_width-1:0] rf_wdata_q, rf_wdata_d;
  logic                 wr_err_q, wr_err_d;

  // An illegal select gates every destination load; increments and clear are independent.
  assign legal = write_sel_legal(write_en_t'(write_en));
  assign ld_ac = legal & write_en[BUS_AC];
  assign ld_pc = legal & write_en[BUS_PC];
  assign ld_ar = legal & write_en[BUS_AR];
  assign ld_ir = legal & write_en[BUS_IR];
  assign ld_rf = legal & write_en[BUS_RF];
  assign ld_dr = legal & write_en[BUS_DR];

  load_inc_reg #(.width(reg_width)) u_ac (
    .clk    (clk),
    .reset  (reset),
    .load_i (ld_ac),
    .clr_i  (clr_ac),
    .inc_i  (1'b0),
    .d_i    (datain),
    .q_o    (AC)
  );

  load_inc_reg #(.width(reg_width)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load_i (ld_pc),
    .clr_i  (1'b0),
    .inc_i  (inc_pc),
    .d_i    (datain),
    .q_o    (PC)
  );

  load_inc_reg #(.width(reg_width)) u_ar (
    .clk    (clk),
    .reset  (reset),
    .load_i (ld_ar),
    .clr_i  (1'b0),
    .inc_i  (inc_ar),
    .d_i    (datain),
    .q_o    (AR)
  );

  always_comb begin
    ir_d       = ld_ir ? datain : ir_q;
    dr_d       = ld_dr ? datain : dr_q;
    rf_we_d    = ld_rf;
    rf_waddr_d = ld_rf ? rf_sel : rf_waddr_q;
    rf_wdata_d = ld_rf ? datain : rf_wdata_q;
    wr_err_d   = wr_err_q;
    if (!legal) begin
      wr_err_d = 1'b1;
    end else if (err_clr) begin
      wr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q       <= '0;
      dr_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      dr_q       <= dr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign IR       = ir_q;
  assign DR       = dr_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_data_bus_sink.sv
// Directed bench for data_bus_sink: hand-computed expectations checked at the falling edge.
module tb_data_bus_sink;

  logic        clk;
  logic        reset;
  logic [11:0] datain;
  logic [15:0] write_en;
  logic [3:0]  rf_sel;
  logic        inc_pc, inc_ar, clr_ac, err_clr;
  logic [11:0] AC, PC, AR, IR, DR;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [11:0] rf_wdata;
  logic        wr_err;

  int checks   = 0;
  int failures = 0;

  data_bus_sink dut (
    .clk      (clk),
    .reset    (reset),
    .datain   (datain),
    .write_en (write_en),
    .rf_sel   (rf_sel),
    .inc_pc   (inc_pc),
    .inc_ar   (inc_ar),
    .clr_ac   (clr_ac),
    .err_clr  (err_clr),
    .AC       (AC),
    .PC       (PC),
    .AR       (AR),
    .IR       (IR),
    .DR       (DR),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .wr_err   (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    write_en = 16'h0000;
    inc_pc   = 1'b0;
    inc_ar   = 1'b0;
    clr_ac   = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic chk_regs(input string tag, input logic [11:0] ac, input logic [11:0] pc,
                          input logic [11:0] ar, input logic [11:0] ir, input logic [11:0] dr);
    chk({tag, ".AC"}, 32'(AC), 32'(ac));
    chk({tag, ".PC"}, 32'(PC), 32'(pc));
    chk({tag, ".AR"}, 32'(AR), 32'(ar));
    chk({tag, ".IR"}, 32'(IR), 32'(ir));
    chk({tag, ".DR"}, 32'(DR), 32'(dr));
  endtask

  initial begin
    idle();
    reset    = 1'b0;
    rf_sel   = 4'h0;
    write_en = 16'h0001;
    datain   = 12'hE08;
    repeat (2) @(negedge clk);
    chk_regs("reset", 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    chk("reset.rf_we", 32'(rf_we), 0);
    chk("reset.rf_waddr", 32'(rf_waddr), 0);
    chk("reset.rf_wdata", 32'(rf_wdata), 0);
    chk("reset.wr_err", 32'(wr_err), 0);

    reset = 1'b1;
    step();
    chk("first_edge.AC", 32'(AC), 32'h0E08);

    write_en = 16'h8000; datain = 12'h188;
    step();
    chk_regs("dr_load", 12'hE08, 12'h0, 12'h0, 12'h0, 12'h188);
    chk("dr_load.rf_we", 32'(rf_we), 0);

    write_en = 16'h0010; rf_sel = 4'h5; datain = 12'hE0F;
    step();
    chk("rf.we", 32'(rf_we), 1);
    chk("rf.waddr", 32'(rf_waddr), 5);
    chk("rf.wdata", 32'(rf_wdata), 32'h0E0F);
    chk("rf.regs_AC", 32'(AC), 32'h0E08);
    write_en = 16'h0000;
    step();
    chk("rf.we_drop", 32'(rf_we), 0);

    write_en = 16'h0010; rf_sel = 4'hA; datain = 12'h321;
    step();
    rf_sel = 4'h3; datain = 12'h654;
    step();
    chk("rf_b2b.we", 32'(rf_we), 1);
    chk("rf_b2b.waddr", 32'(rf_waddr), 3);
    chk("rf_b2b.wdata", 32'(rf_wdata), 32'h0654);
    write_en = 16'h0000;
    step();

    write_en = 16'h0002; datain = 12'hFFF;
    step();
    chk("pc_load", 32'(PC), 32'h0FFF);
    write_en = 16'h0000; inc_pc = 1'b1;
    step();
    chk("pc_wrap", 32'(PC), 32'h0000);
    write_en = 16'h0002; datain = 12'h123;
    step();
    chk("pc_load_beats_inc", 32'(PC), 32'h0123);
    idle();

    write_en = 16'h0004; datain = 12'hFFE;
    step();
    write_en = 16'h0000; inc_ar = 1'b1;
    step();
    chk("ar_inc", 32'(AR), 32'h0FFF);
    step();
    chk("ar_wrap", 32'(AR), 32'h0000);
    idle();
    write_en = 16'h0008; datain = 12'h5A5;
    step();
    chk_regs("ir_load", 12'hE08, 12'h123, 12'h0, 12'h5A5, 12'h188);

    write_en = 16'h0021; datain = 12'h111; inc_pc = 1'b1;
    step();
    chk_regs("illegal_multi", 12'hE08, 12'h124, 12'h0, 12'h5A5, 12'h188);
    chk("illegal_multi.wr_err", 32'(wr_err), 1);
    chk("illegal_multi.rf_we", 32'(rf_we), 0);
    idle();
    write_en = 16'h0020; datain = 12'h222;
    step();
    chk_regs("illegal_rsvd", 12'hE08, 12'h124, 12'h0, 12'h5A5, 12'h188);
    chk("illegal_rsvd.wr_err", 32'(wr_err), 1);
    write_en = 16'h0003; err_clr = 1'b1; datain = 12'h333;
    step();
    chk("set_beats_clr.wr_err", 32'(wr_err), 1);
    chk("set_beats_clr.AC", 32'(AC), 32'h0E08);
    chk("set_beats_clr.PC", 32'(PC), 32'h0124);
    write_en = 16'h0000;
    step();
    chk("err_clr.wr_err", 32'(wr_err), 0);
    idle();

    write_en = 16'h0001; clr_ac = 1'b1; datain = 12'h0AA;
    step();
    chk("ac_load_beats_clr", 32'(AC), 32'h00AA);
    write_en = 16'h0000;
    step();
    chk("ac_clr", 32'(AC), 0);
    idle();

    write_en = 16'h0010; rf_sel = 4'h7; datain = 12'h777;
    @(posedge clk);
    #1;
    chk("pre_reset.rf_we", 32'(rf_we), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset.rf_we", 32'(rf_we), 0);
    chk("async_reset.rf_waddr", 32'(rf_waddr), 0);
    chk("async_reset.PC", 32'(PC), 0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_bus_sink.md
# data_bus_sink

Write end of the processor's shared data bus: takes the value driven on `datain` by the bus mux and, under one-hot `write_en` control, loads it into AC, PC, AR, IR or DR, or forwards it to the register file write port. Also provides PC/AR increment and AC clear, and flags illegal write selects. Sits between the bus mux output and the architectural registers, driven by the control unit each cycle.

## Interface
- `Reg_count`, 16, width of `write_en`; one bit per bus destination
- `reg_width`, 12, data width of bus and all registers
- `RF_ADDR_W`, 4, register-file address width
- `clk`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `datain`  input  reg_width  current bus value
- `write_en`  input  Reg_count  one-hot destination select; bit0 AC, bit1 PC, bit2 AR, bit3 IR, bit4 register file, bit15 DR, bits 5–14 reserved
- `rf_sel`  input  RF_ADDR_W  register-file destination address, sampled with `write_en[4]`
- `inc_pc`  input  1  increment PC
- `inc_ar`  input  1  increment AR
- `clr_ac`  input  1  clear AC
- `err_clr`  input  1  clear sticky error flag
- `AC`, `PC`, `AR`, `IR`, `DR`  output  reg_width each  architectural registers
- `rf_we`  output  1  register-file write strobe
- `rf_waddr`  output  RF_ADDR_W  register-file write address
- `rf_wdata`  output  reg_width  register-file write data
- `wr_err`  output  1  sticky illegal-select flag

## Operation
- Legal `write_en`: all-zero (no write) or exactly one bit among {0,1,2,3,4,15} set.
- Legal single bit: selected destination loads `datain` at the rising edge.
- Bit4: `rf_wdata` <= `datain`, `rf_waddr` <= `rf_sel`, `rf_we` <= 1 for one cycle. `rf_we` falls back to 0 in the next cycle unless bit4 is asserted again.
- Illegal `write_en` (more than one bit set, or any reserved bit set): no destination updates and `rf_we` <= 0. `wr_err` <= 1. Increments and clear still apply.
- `inc_pc`/`inc_ar`: register <= register + 1, modulo 2^reg_width. 12'hFFF wraps to 12'h000.
- `clr_ac`: AC <= 0.
- Priority per register: a bus write beats an increment or clear in the same cycle. `inc_pc` with a PC write loads `datain`. `clr_ac` with an AC write loads `datain`.
- `wr_err`: set by an illegal select, cleared by `err_clr`. If both occur in the same cycle, set wins.
- Reset (`reset`=0, asynchronous): AC, PC, AR, IR, DR, `rf_wdata` = 0; `rf_waddr` = 0; `rf_we` = 0; `wr_err` = 0. Reset asserted mid-operation aborts any pending `rf_we` immediately.

## Timing
- Inputs sampled at the rising edge. The new register value is visible on outputs in the cycle after (latency 1).
- The `rf_we` pulse is aligned with `rf_waddr`/`rf_wdata` in that same following cycle. Back-to-back bit4 writes produce a continuous `rf_we` with new address/data each cycle.
- No handshake; the control unit guarantees `datain` is stable at the sampling edge.
- Reset release is synchronous to `clk` in effect. The first update occurs on the first rising edge with `reset`=1.

## Structure
- Shared package (also used by the bus mux): bus index localparams BUS_AC=0, BUS_PC=1, BUS_AR=2, BUS_IR=3, BUS_RF=4, BUS_DR=15; default widths.
- Legality check is a combinational function in the package: one-hot test masked by the legal-bit set.
- Sub-module `load_inc_reg` (load/inc/clear register, parameter width; load > clear > inc). Instantiated for AC, PC and AR. IR and DR use plain load-only flops.

## Test plan
- Reset with `write_en`=16'h0001, `datain`=12'hE08 held → all outputs 0. Release reset → AC=12'hE08 one cycle after the first edge.
- `write_en`=16'h8000, `datain`=12'h188 → DR=12'h188. Every other register is unchanged and `rf_we`=0.
- `write_en`=16'h0010, `rf_sel`=4'h5, `datain`=12'hE0F, then `write_en`=0 → `rf_we` high for exactly one cycle with `rf_waddr`=5 and `rf_wdata`=12'hE0F.
- PC=12'hFFF, `inc_pc`=1 → PC=12'h000. Next cycle: `inc_pc`=1 with `write_en`=16'h0002, `datain`=12'h123 → PC=12'h123.
- `write_en`=16'h0021, then 16'h0020 → no register changes and `wr_err`=1 after the first. `err_clr` together with 16'h0003 keeps `wr_err`=1. `err_clr` alone → `wr_err`=0.
- `clr_ac`=1 with `write_en`=16'h0001, `datain`=12'h0AA → AC=12'h0AA. `clr_ac` alone → AC=0. Assert `reset` asynchronously during an `rf_we` pulse → `rf_we` drops immediately.
